// File: rtl/stack_frame_ctrl.sv
// rtl/stack_frame_ctrl.sv - call/return frame sequencer driving a SuperStack
// Optional FRAME_LOCALS_EN: zero-filled locals allocation on call through an extra LOC_OP step.
module stack_frame_ctrl #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 3,
   parameter int FRAMES = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_call,
   input  logic [DEPTH:0]                 req_count,
   input  logic [DEPTH:0]                 req_locals,
   output logic                           done,
   output logic [1:0]                     fault,
   output logic [$clog2(FRAMES+1)-1:0]    frame_depth,
   output logic [2:0]                     st_op,
   output logic [WIDTH-1:0]               st_data,
   output logic [DEPTH:0]                 st_offset,
   output logic [DEPTH:0]                 st_underflow_limit,
   output logic [DEPTH:0]                 st_upper_limit,
   input  logic [DEPTH:0]                 st_index,
   input  logic [WIDTH-1:0]               st_out,
   input  logic [1:0]                     st_error
);

   localparam int FD_W = $clog2(FRAMES + 1);

   // Encodings mirror SuperStack.vh
   localparam logic [2:0] OP_NONE                 = 3'd0;
   localparam logic [2:0] OP_INDEX_RESET          = 3'd6;
   localparam logic [2:0] OP_INDEX_RESET_AND_PUSH = 3'd7;

   localparam logic [DEPTH:0]  CNT_ONE  = 1;
   localparam logic [FD_W-1:0] FD_FULL  = FD_W'(FRAMES);
   localparam logic [FD_W-1:0] FD_ONE   = 1;

   localparam logic [1:0] F_NONE  = 2'b00;
   localparam logic [1:0] F_FULL  = 2'b01;
   localparam logic [1:0] F_BAD   = 2'b10;
   localparam logic [1:0] F_STACK = 2'b11;

   typedef enum logic [2:0] {IDLE, RET_OP, RET_RESTORE, LOC_OP, FINISH} state_t;

   state_t state;

   // Saved caller limits {underflow_limit, upper_limit}, indexed by frame depth
   logic [2*(DEPTH+1)-1:0] frame_mem [2**FD_W];

   logic [DEPTH:0] avail;
   logic           call_full;
   logic           call_bad;
   logic           call_take;
   logic           ret_bad;
   logic [1:0]     err_fault;

   always_comb begin
      avail     = st_index - st_underflow_limit;
      call_full = (frame_depth == FD_FULL);
      call_bad  = (req_count > avail);
      call_take = (state == IDLE) && req_valid && req_call && !call_full && !call_bad;
      ret_bad   = (frame_depth == '0) || (req_count > CNT_ONE);
      err_fault = (st_error != 2'b00) ? F_STACK : F_NONE;
   end

`ifdef FRAME_LOCALS_EN
   logic call_locals;
   assign call_locals = (req_locals != '0);
`else
   logic unused_locals;
   assign unused_locals = ^req_locals;
`endif

   always_ff @(posedge clk) begin
      if (reset && call_take) begin
         frame_mem[frame_depth] <= {st_underflow_limit, st_upper_limit};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= IDLE;
         req_ready          <= 1'b1;
         done               <= 1'b0;
         fault              <= F_NONE;
         frame_depth        <= '0;
         st_op              <= OP_NONE;
         st_data            <= '0;
         st_offset          <= '0;
         st_underflow_limit <= '0;
         st_upper_limit     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_call) begin
                  if (call_full) begin
                     done  <= 1'b1;
                     fault <= F_FULL;
                  end else if (call_bad) begin
                     done  <= 1'b1;
                     fault <= F_BAD;
                  end else begin
                     st_underflow_limit <= st_index - req_count;
                     st_upper_limit     <= st_index;
                     frame_depth        <= frame_depth + FD_ONE;
                     fault              <= F_NONE;
`ifdef FRAME_LOCALS_EN
                     if (call_locals) begin
                        state     <= LOC_OP;
                        req_ready <= 1'b0;
                        st_op     <= OP_INDEX_RESET;
                        st_offset <= st_index + req_locals;
                     end else begin
                        done <= 1'b1;
                     end
`else
                     done <= 1'b1;
`endif
                  end
               end else if (req_valid) begin
                  if (ret_bad) begin
                     done  <= 1'b1;
                     fault <= F_BAD;
                  end else begin
                     // Result (if any) lands at the frame base, dropping the callee's slots
                     state     <= RET_OP;
                     req_ready <= 1'b0;
                     fault     <= F_NONE;
                     st_offset <= st_underflow_limit;
                     if (req_count == CNT_ONE) begin
                        st_op   <= OP_INDEX_RESET_AND_PUSH;
                        st_data <= st_out;
                     end else begin
                        st_op <= OP_INDEX_RESET;
                     end
                  end
               end
            end
            RET_OP: begin
               st_op <= OP_NONE;
               {st_underflow_limit, st_upper_limit} <= frame_mem[frame_depth - FD_ONE];
               frame_depth <= frame_depth - FD_ONE;
               done        <= 1'b1;
               fault       <= err_fault;
               state       <= RET_RESTORE;
            end
            LOC_OP: begin
               st_op <= OP_NONE;
               done  <= 1'b1;
               fault <= err_fault;
               state <= FINISH;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// tb/tb_stack_frame_ctrl.sv - directed and randomized checks of stack_frame_ctrl against a frame model
module tb_stack_frame_ctrl;

   localparam logic [2:0] OPN  = 3'd0;
   localparam logic [2:0] OPR  = 3'd6;
   localparam logic [2:0] OPRP = 3'd7;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_call, done;
   logic [3:0] req_count, req_locals;
   logic [1:0] fault, frame_depth, st_error;
   logic [2:0] st_op;
   logic [7:0] st_data, st_out;
   logic [3:0] st_offset, st_underflow_limit, st_upper_limit, st_index;

   always #5 clk = ~clk;

   stack_frame_ctrl #(.WIDTH(8), .DEPTH(3), .FRAMES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_call(req_call), .req_count(req_count), .req_locals(req_locals),
      .done(done), .fault(fault), .frame_depth(frame_depth), .st_op(st_op),
      .st_data(st_data), .st_offset(st_offset), .st_underflow_limit(st_underflow_limit),
      .st_upper_limit(st_upper_limit), .st_index(st_index), .st_out(st_out),
      .st_error(st_error)
   );

   // Operand stack stand-in with a direct push port for the bench
   logic [7:0] smem [16];
   logic [3:0] sidx;
   logic       push_en;
   logic [7:0] push_val;
   logic [1:0] err_inj;

   assign st_index = sidx;
   assign st_out   = smem[sidx - 4'd1];
   assign st_error = err_inj;

   always @(posedge clk) begin
      if (!reset) begin
         sidx <= 4'd0;
         for (int i = 0; i < 16; i++) smem[i] <= 8'd0;
      end else if (push_en) begin
         smem[sidx] <= push_val;
         sidx       <= sidx + 4'd1;
      end else if (st_op == OPRP) begin
         smem[st_offset] <= st_data;
         sidx            <= st_offset + 4'd1;
      end else if (st_op == OPR) begin
         for (int i = 0; i < 16; i++)
            if (i >= int'(sidx) && i < int'(st_offset)) smem[i] <= 8'd0;
         sidx <= st_offset;
      end
   end

   // Frame model: caller limits kept in a queue
   int r_ul, r_up, r_depth;
   int fq[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      r_ul = 0; r_up = 0; r_depth = 0;
      fq.delete();
   endtask

   task automatic chk_frame(input string tag);
      chk({tag, ".ul"}, st_underflow_limit, r_ul);
      chk({tag, ".up"}, st_upper_limit, r_up);
      chk({tag, ".depth"}, frame_depth, r_depth);
   endtask

   task automatic push(input int v);
      push_en = 1'b1; push_val = 8'(v);
      cyc();
      push_en = 1'b0;
   endtask

   task automatic do_call(input string tag, input int count, input int locals);
      int idx, exp_fault;
      bit loc;
      idx = int'(sidx);
      if (r_depth == 2) exp_fault = 1;
      else if (count > ((idx - r_ul) & 15)) exp_fault = 2;
      else exp_fault = 0;
      loc = 1'b0;
`ifdef FRAME_LOCALS_EN
      loc = (exp_fault == 0) && (locals != 0);
`endif
      chk({tag, ".ready"}, req_ready, 1);
      req_valid = 1'b1; req_call = 1'b1; req_count = 4'(count); req_locals = 4'(locals);
      cyc();
      req_valid = 1'b0;
      if (exp_fault == 0) begin
         fq.push_back(r_ul * 16 + r_up);
         r_ul = (idx - count) & 15; r_up = idx; r_depth++;
      end
      if (loc) begin
         chk({tag, ".loc_done"}, done, 0);
         chk({tag, ".loc_op"}, st_op, OPR);
         chk({tag, ".loc_off"}, st_offset, (idx + locals) & 15);
         cyc();
         chk({tag, ".loc_idx"}, sidx, (idx + locals) & 15);
      end else begin
         chk({tag, ".op"}, st_op, OPN);
      end
      chk({tag, ".done"}, done, 1);
      chk({tag, ".fault"}, fault, exp_fault);
      chk_frame(tag);
      cyc();
      chk({tag, ".done_drop"}, done, 0);
   endtask

   task automatic do_return(input string tag, input int count, input logic [1:0] err);
      int idx, top, base, saved;
      idx  = int'(sidx);
      top  = int'(smem[4'(idx - 1)]);
      base = r_ul;
      chk({tag, ".ready"}, req_ready, 1);
      req_valid = 1'b1; req_call = 1'b0; req_count = 4'(count); req_locals = 4'd0;
      cyc();
      req_valid = 1'b0;
      if (r_depth == 0 || count > 1) begin
         chk({tag, ".done"}, done, 1);
         chk({tag, ".fault"}, fault, 2);
         chk({tag, ".op"}, st_op, OPN);
         chk_frame(tag);
         cyc();
      end else begin
         chk({tag, ".done_early"}, done, 0);
         chk({tag, ".busy"}, req_ready, 0);
         chk({tag, ".op"}, st_op, (count == 1) ? OPRP : OPR);
         chk({tag, ".off"}, st_offset, base);
         if (count == 1) chk({tag, ".data"}, st_data, top);
         err_inj = err;
         cyc();
         err_inj = 2'b00;
         saved = fq.pop_back();
         r_ul = saved / 16; r_up = saved % 16; r_depth--;
         chk({tag, ".done"}, done, 1);
         chk({tag, ".fault"}, fault, (err != 2'b00) ? 3 : 0);
         chk({tag, ".op_end"}, st_op, OPN);
         chk({tag, ".idx"}, sidx, base + count);
         chk_frame(tag);
         cyc();
         chk({tag, ".ready_back"}, req_ready, 1);
      end
      chk({tag, ".done_drop"}, done, 0);
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_call = 1'b0; req_count = 4'd0; req_locals = 4'd0;
      push_en = 1'b0; push_val = 8'd0; err_inj = 2'b00;
      model_reset();
      @(negedge clk);
      cyc();
      reset = 1'b1;
      chk("rst.op", st_op, OPN);
      chk("rst.ready", req_ready, 1);
      chk("rst.done", done, 0);
      chk("rst.fault", fault, 0);
      chk("rst.data", st_data, 0);
      chk("rst.off", st_offset, 0);
      chk_frame("rst");

      push(11); push(22); push(33);
      chk("push.idx", sidx, 3);
      do_call("call2", 2, 0);
      do_return("ret1", 1, 2'b00);
      chk("ret1.out", st_out, 33);
      chk("ret1.out1", smem[0], 11);

      do_call("nest1", 0, 0);
      do_call("nest2", 0, 0);
      do_call("nest3", 0, 0);
      do_return("unw1", 0, 2'b00);
      do_return("unw2", 0, 2'b00);
      do_return("empty", 0, 2'b00);

      push(44);
      do_call("bigcnt", 4, 0);
      do_call("ok1", 1, 3);
      do_return("cnt2", 2, 2'b00);
      do_return("errret", 1, 2'b10);

      for (int n = 0; n < 80; n++) begin
         int sel, avail;
         sel = $urandom_range(0, 3);
         avail = (int'(sidx) - r_ul) & 15;
         if (sel == 0 && sidx < 4'd7)
            push($urandom_range(1, 255));
         else if (sel == 1)
            do_call("rcall", $urandom_range(0, (avail < 14) ? avail + 1 : avail),
                    (sidx < 4'd5) ? $urandom_range(0, 2) : 0);
         else
            do_return("rret", $urandom_range(0, 2),
                      ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00);
      end

      while (r_depth > 0) do_return("drain", 0, 2'b00);
      do_call("pre_rst", 0, 0);
      req_valid = 1'b1; req_call = 1'b0; req_count = 4'd0;
      cyc();
      req_valid = 1'b0;
      chk("midrst.inret", st_op, OPR);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      model_reset();
      chk("midrst.op", st_op, OPN);
      chk("midrst.ready", req_ready, 1);
      chk("midrst.done", done, 0);
      chk_frame("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
